// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central hazard controller for the 5-stage MIPS core. Watches the instruction
// in the register-read (RD) stage and its neighbours in EX and MEM. From these
// it decides when to stall the front end, insert a bubble into EX, freeze the
// back end, or flush IF/RD. It also selects forwarding sources for both RD read
// values and tracks the multi-cycle mult/div unit with a busy counter.
//
// Optional build macro: HAZARD_STATS_EN adds stall/flush event counters.
//
// Parameters:
//   MULDIV_CYCLES  cycles the mult/div unit stays busy after an accepted start
//   CNT_W          busy counter width (2**CNT_W must exceed MULDIV_CYCLES)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_rs, id_rt             RD-stage source registers
//   id_uses_rs, id_uses_rt   RD instruction actually reads rs / rt
//   id_uses_hilo             RD instruction is mfhi/mflo
//   id_is_muldiv             RD instruction is mult/multu/div/divu
//   ex_rd, ex_register_write, ex_is_load   EX-stage destination info
//   mem_rd, mem_register_write             MEM-stage destination info
//   ex_branch_taken          branch/jump resolved taken in EX
//   mem_busy                 data memory not ready
//   stall                    hold PC and IF/RD
//   bubble                   load a NOP into RD/EX
//   freeze                   hold RD/EX, EX/MEM, MEM/WB
//   flush                    replace IF/RD with a NOP
//   forward_1, forward_2     0 = regfile, 1 = EX result, 2 = MEM result
//   muldiv_busy              mult/div unit occupied
//   stall_count, flush_count (HAZARD_STATS_EN only) event counters

module pipeline_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_uses_hilo,
    input  logic       id_is_muldiv,
    input  logic [4:0] ex_rd,
    input  logic       ex_register_write,
    input  logic       ex_is_load,
    input  logic [4:0] mem_rd,
    input  logic       mem_register_write,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    output logic       stall,
    output logic       bubble,
    output logic       freeze,
    output logic       flush,
    output logic [1:0] forward_1,
    output logic [1:0] forward_2,
    output logic       muldiv_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    logic [CNT_W-1:0] cnt;
    logic             ex_match_1;
    logic             ex_match_2;
    logic             mem_match_1;
    logic             mem_match_2;
    logic             load_use;
    logic             muldiv_hz;
    logic             muldiv_start;

    // Register 0 is hardwired to zero, so it can never carry a dependency.
    assign ex_match_1  = id_uses_rs & ex_register_write  & (ex_rd  == id_rs) & (id_rs != 5'd0);
    assign ex_match_2  = id_uses_rt & ex_register_write  & (ex_rd  == id_rt) & (id_rt != 5'd0);
    assign mem_match_1 = id_uses_rs & mem_register_write & (mem_rd == id_rs) & (id_rs != 5'd0);
    assign mem_match_2 = id_uses_rt & mem_register_write & (mem_rd == id_rt) & (id_rt != 5'd0);

    // A load result is not available until MEM, so a consumer right behind it
    // must wait one cycle; afterwards the MEM forward picks it up.
    assign load_use    = ex_is_load & (ex_match_1 | ex_match_2);
    assign muldiv_busy = (cnt != '0);
    // Reading HI/LO or issuing another mult/div has to wait for the unit.
    assign muldiv_hz   = muldiv_busy & (id_uses_hilo | id_is_muldiv);

    // Pipe control. A taken branch wins even over mem_busy: the pipe registers
    // apply the freeze themselves, and the wrong-path instruction must die.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
        if (ex_branch_taken) begin
            flush  = 1'b1;
            bubble = 1'b1;
        end else if (mem_busy) begin
            freeze = 1'b1;
            stall  = 1'b1;
        end else if (load_use | muldiv_hz) begin
            stall  = 1'b1;
            bubble = 1'b1;
        end
    end

    // Forward selection, EX has priority because it holds the youngest value.
    // A load in EX has no result yet, so it is never an EX forward source.
    always_comb begin
        forward_1 = 2'd0;
        forward_2 = 2'd0;
        if (ex_match_1 & ~ex_is_load) begin
            forward_1 = 2'd1;
        end else if (mem_match_1) begin
            forward_1 = 2'd2;
        end
        if (ex_match_2 & ~ex_is_load) begin
            forward_2 = 2'd1;
        end else if (mem_match_2) begin
            forward_2 = 2'd2;
        end
    end

    // A mult/div only starts when it actually advances out of RD this cycle.
    assign muldiv_start = id_is_muldiv & ~stall & ~flush & ~freeze;

    // Busy counter. It runs independently of pipe stalls and saturates at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (muldiv_start) begin
            cnt <= CNT_W'(MULDIV_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

`ifdef HAZARD_STATS_EN
    // Performance counters, free-running and wrapping at 2**32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (stall) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS core; sequences the register-read (RD) stage and the stages around it.
- Generates `stall` to IF/RD, bubble insertion into EX, and flush of IF/RD on taken branches.
- Generates the forwarding selects for the two RD read values.
- Tracks the multi-cycle multiply/divide unit with an internal busy counter.

Parameters:
- MULDIV_CYCLES, 32, cycles the mult/div unit stays busy after a start is accepted (legal range 1..63).
- CNT_W, 6, width of the busy counter; must satisfy 2^CNT_W > MULDIV_CYCLES.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_rs  input  5  source register 1 of the instruction in RD.
- id_rt  input  5  source register 2 of the instruction in RD.
- id_uses_rs  input  1  instruction in RD reads id_rs.
- id_uses_rt  input  1  instruction in RD reads id_rt.
- id_uses_hilo  input  1  instruction in RD is mfhi/mflo.
- id_is_muldiv  input  1  instruction in RD is mult/multu/div/divu.
- ex_rd  input  5  destination of the instruction in EX.
- ex_register_write  input  1  EX instruction writes ex_rd.
- ex_is_load  input  1  EX instruction is a load.
- mem_rd  input  5  destination of the instruction in MEM.
- mem_register_write  input  1  MEM instruction writes mem_rd.
- ex_branch_taken  input  1  branch/jump resolved taken in EX this cycle.
- mem_busy  input  1  data memory not ready; whole pipe must freeze.
- stall  output  1  hold PC and the IF/RD register.
- bubble  output  1  load a NOP (register_write=0, branch=0) into the RD/EX register.
- freeze  output  1  hold the RD/EX, EX/MEM and MEM/WB registers.
- flush  output  1  replace IF/RD contents with a NOP.
- forward_1  output  2  value_1 source: 0 = register file, 1 = EX result, 2 = MEM result.
- forward_2  output  2  value_2 source, same encoding as forward_1.
- muldiv_busy  output  1  mult/div unit occupied.

Behaviour:
- Register 0 never matches any hazard or forward condition.
- `ex_match_1` = id_uses_rs & ex_register_write & ex_rd==id_rs & id_rs!=0. `ex_match_2` is the same with rt. `mem_match_1/2` are analogous using mem_rd/mem_register_write.
- `load_use` = ex_is_load & (ex_match_1 | ex_match_2).
- `muldiv_hz` = muldiv_busy & (id_uses_hilo | id_is_muldiv).
- All outputs except muldiv_busy are combinational from inputs and current state, with this priority (highest first):
  1. ex_branch_taken → flush=1, bubble=1, stall=0, freeze=0. mem_busy is ignored by this block that cycle; the pipe registers handle it.
  2. mem_busy → freeze=1, stall=1, bubble=0, flush=0.
  3. load_use | muldiv_hz → stall=1, bubble=1, flush=0, freeze=0.
  4. Otherwise all four are 0.
- forward_1: 1 if ex_match_1 & !ex_is_load, else 2 if mem_match_1, else 0. EX has priority over MEM. forward_2 is identical using rt. Forwards are driven regardless of stall state.
- Busy counter `cnt` (CNT_W bits) is the only state. muldiv_busy = (cnt != 0).
  - Start accepted when id_is_muldiv & stall==0 & flush==0 & freeze==0. On the next edge, cnt = MULDIV_CYCLES.
  - Otherwise, if cnt != 0, cnt decrements by 1 every edge, including during freeze/stall/flush; the unit runs independently of the pipe.
  - cnt saturates at 0; no wrap.
  - A start cannot coincide with busy, because muldiv_hz forces a stall.
  - Result: busy is high exactly MULDIV_CYCLES cycles after the accepting edge.
- Reset asserted asynchronously, including mid-count: cnt=0 immediately, so muldiv_busy=0.
  - Combinational outputs then follow the inputs under the rules above with cnt=0.
  - With all inputs 0 during reset, every output is 0.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds outputs `stall_count` [31:0] and `flush_count` [31:0].
  - stall_count increments on every edge where stall==1.
  - flush_count increments on every edge where flush==1.
  - Both wrap modulo 2^32 and clear to 0 on rst.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
1. EX: lw, ex_rd=5, ex_register_write=1, ex_is_load=1; RD: id_rs=5, id_uses_rs=1 → stall=1, bubble=1 for that cycle. Next cycle, with EX now holding the bubble and MEM holding rd=5 → stall=0, forward_1=2.
2. EX: add, ex_rd=3, non-load; MEM: mem_rd=3, both writing; RD: id_rt=3, id_uses_rt=1 → forward_2=1, no stall. With id_rt=0 and ex_rd=0 → forward_2=0.
3. MULDIV_CYCLES=4:
   - mult accepted at edge N → muldiv_busy high for edges N..N+3, low after edge N+4.
   - mfhi presented at N+1 → stall=1, bubble=1 until busy falls, then released.
4. ex_branch_taken=1 together with a load_use condition and mem_busy=1 → flush=1, bubble=1, stall=0, freeze=0.
5. mem_busy=1 for 3 cycles, no other hazard → freeze=stall=1 and bubble=0 for all 3 cycles. A running muldiv counter still decrements by 3 over that window.
6. Assert rst asynchronously mid-count (cnt=2) → muldiv_busy drops before the next clk edge. With HAZARD_STATS_EN defined, stall_count=flush_count=0 after reset.
